mbm_mult_scheduler: RTL and testbench
=====================================

// Module: mbm_mult_scheduler
// PURPOSE
//  Shares one combinational MBM_multiplier (8b x 8b -> 16b approximate product) among NUM_REQ requesters.
//  Round-robin grant, valid/ready handshake per requester, registered operand and product stages.
//  Each result returns tagged with the requester ID.
//  Sits between MAC lanes and the single shared MBM multiplier instance.
// PARAMETERS
//  NUM_REQ    4  number of requesters (2..16)
//  BIT_WIDTH  8  operand width; fixed at 8 by MBM_multiplier; any other value is an elaboration error
//  ID_W       $clog2(NUM_REQ)  width of the result tag (localparam)
// PORTS
//  clk          in   1              single clock, rising edge
//  rst_n        in   1              synchronous, active-low reset
//  req_valid    in   NUM_REQ        per-requester operand valid
//  req_a        in   NUM_REQ*BIT_WIDTH  packed operand A; requester i uses bits [i*BW +: BW]
//  req_b        in   NUM_REQ*BIT_WIDTH  packed operand B, same packing as req_a
//  req_ready    out  NUM_REQ        one-hot (or zero) grant; a transfer happens when valid & ready
//  rsp_valid    out  1              result valid
//  rsp_product  out  2*BIT_WIDTH    MBM product
//  rsp_id       out  ID_W           index of the requester that issued the result
//  rsp_ready    in   1              downstream accepts the result
//  op_count     out  32             count of accepted results (rsp_valid & rsp_ready); wraps to 0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): stage valids=0, rr pointer=0, op_count=0.
//    req_ready=0, rsp_valid=0, rsp_product=0, rsp_id=0.
//    Reset mid-operation discards all in-flight ops; nothing is replayed.
//  Pipeline: S1 = operand reg {a, b, id, v1}; S2 = product reg {product, id, v2}.
//    Multiplier sits combinationally between S1 and S2.
//    Latency: a handshake at edge N gives rsp_valid=1 after edge N+1, when S2 is not stalled.
//  Stall: s2_adv = !v2 | rsp_ready; s1_adv = !v1 | s2_adv.
//    S2 loads from S1 when s2_adv. S1 loads the granted request when s1_adv.
//    S2 holds product/id stable while rsp_valid & !rsp_ready.
//  Arbitration: combinational round-robin. Search starts at pointer p and goes up, wrapping at NUM_REQ-1 -> 0.
//    The first requester with req_valid=1 is granted.
//    req_ready[g]=1 only when s1_adv=1 and rst_n=1. All other bits are 0.
//    After a transfer to g, p <= (g+1) mod NUM_REQ. No transfer: p holds.
//    req_ready may depend on req_valid (it is not valid-independent). Requesters must hold valid/data until ready.
//  Throughput: 1 op/cycle when rsp_ready=1 continuously. Full-pipe stall holds 2 ops; none are dropped or duplicated.
//  Simultaneous events: S2 drain and S1->S2 move in the same cycle are both allowed.
//    New grant into S1 in the same cycle S1 empties is allowed.
//  op_count: +1 per rsp handshake. 32'hFFFF_FFFF wraps to 0.
//  No FSM beyond the two valid bits. States {v1,v2}: 00 idle, 10 filling, 01 draining, 11 full.
//  Any X on req_valid after reset is an assertion failure in simulation.
// STRUCTURE
//  Package mbm_sched_pkg: MBM_BW=8, MBM_PROD_W=16, CNT_W=32, function rr_next(ptr, n).
//  Sub-module mbm_rr_arbiter (req vector + pointer + enable -> one-hot grant, grant index).
//  Instantiates MBM_multiplier once (operand_a, operand_b, product) fed from S1.
//  The rest is pipeline registers + counter in this module.
// TESTING  (golden product = standalone MBM_multiplier model output for the same operands)
//  1 Reset: hold rst_n=0 5 cycles with all req_valid=1.
//    -> req_ready=0, rsp_valid=0, op_count=0 throughout.
//  2 Single op: req0 a=8'd3 b=8'd5 for 1 handshake, rsp_ready=1.
//    -> rsp_valid exactly 2 edges later, rsp_id=0, product=golden(3,5), op_count=1.
//  3 Round robin: all 4 valid continuously, rsp_ready=1.
//    -> grant order 0,1,2,3,0,1...; rsp_id stream matches; 1 rsp/cycle.
//  4 Backpressure: 4 valid, rsp_ready=0 for 6 cycles then 1.
//    -> exactly 2 ops accepted, req_ready=0 while full.
//    -> rsp_product/rsp_id stable during stall; no loss or duplication after release.
//  5 Wrap: req3 only, pointer at 3. -> grant 3, pointer becomes 0.
//    Then req0 and req2 valid -> grant 0 first.
//  6 Reset mid-flight: rst_n=0 one cycle with v1=v2=1.
//    -> next cycle rsp_valid=0, op_count=0, p=0.
//  Plus 10k random ops vs scoreboard keyed by id; op_count forced to 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/mbm_sched_pkg.sv
// Shared constants and helpers for the MBM multiplier scheduler.
package mbm_sched_pkg;

    localparam int unsigned MBM_BW     = 8;
    localparam int unsigned MBM_PROD_W = 16;
    localparam int unsigned CNT_W      = 32;

    // Round-robin successor: index after ptr, wrapping from n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/MBM_multiplier.sv
// Approximate 8x8 logarithmic multiplier. Each operand is split into its
// leading-one position k and remainder r; the r_a*r_b cross term is dropped,
// and when the fractional sum overflows the result is taken as 2*(fraction sum).
module MBM_multiplier
    import mbm_sched_pkg::*;
(
    input  logic [MBM_BW-1:0]     operand_a,
    input  logic [MBM_BW-1:0]     operand_b,
    output logic [MBM_PROD_W-1:0] product
);

    logic [2:0]            w_ka;
    logic [2:0]            w_kb;
    logic [MBM_BW-1:0]     w_ra;
    logic [MBM_BW-1:0]     w_rb;
    logic [MBM_PROD_W-1:0] w_sum;
    logic [MBM_PROD_W-1:0] w_base;

    function automatic logic [2:0] lead_one(input logic [MBM_BW-1:0] v);
        logic [2:0] pos;
        pos = '0;
        for (int unsigned i = 0; i < MBM_BW; i++) begin
            if (v[i]) pos = 3'(i);
        end
        return pos;
    endfunction

    // Log-domain decomposition and approximate product assembly.
    always_comb begin
        w_ka   = lead_one(operand_a);
        w_kb   = lead_one(operand_b);
        w_ra   = operand_a & ~(8'd1 << w_ka);
        w_rb   = operand_b & ~(8'd1 << w_kb);
        w_sum  = ({8'b0, w_ra} << w_kb) + ({8'b0, w_rb} << w_ka);
        w_base = 16'd1 << ({1'b0, w_ka} + {1'b0, w_kb});
        if (operand_a == '0 || operand_b == '0) begin
            product = '0;
        end else if (w_sum < w_base) begin
            product = w_base + w_sum;
        end else begin
            product = w_sum << 1;
        end
    end

endmodule

// File: rtl/mbm_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps.
module mbm_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    // Pick the first requester at or after the pointer; grant only when enabled.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!o_gnt_vld && i_req[IDX_W'(idx)]) begin
                o_gnt_vld = 1'b1;
                o_gnt_idx = IDX_W'(idx);
            end
        end
        if (i_en && o_gnt_vld) o_gnt[o_gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/mbm_mult_scheduler.sv
// Shares one MBM_multiplier among NUM_REQ requesters: round-robin grant into
// an operand stage (S1), combinational multiply, product stage (S2) with
// valid/ready backpressure and an accepted-result counter.
module mbm_mult_scheduler
    import mbm_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned BIT_WIDTH = 8,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rsp_valid,
    output logic [2*BIT_WIDTH-1:0]         rsp_product,
    output logic [ID_W-1:0]                rsp_id,
    input  logic                           rsp_ready,
    output logic [CNT_W-1:0]               op_count
);

    if (BIT_WIDTH != MBM_BW) begin : g_bw_check
        $error("mbm_mult_scheduler: BIT_WIDTH must be 8");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_nreq_check
        $error("mbm_mult_scheduler: NUM_REQ must be 2..16");
    end

    logic                   r_v1;
    logic [BIT_WIDTH-1:0]   r_s1_a;
    logic [BIT_WIDTH-1:0]   r_s1_b;
    logic [ID_W-1:0]        r_s1_id;
    logic                   r_v2;
    logic [2*BIT_WIDTH-1:0] r_s2_prod;
    logic [ID_W-1:0]        r_s2_id;
    logic [ID_W-1:0]        r_ptr;
    logic [CNT_W-1:0]       r_op_count;

    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_arb_en;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [ID_W-1:0]        w_gnt_idx;
    logic                   w_gnt_vld;
    logic                   w_xfer;
    logic [BIT_WIDTH-1:0]   w_sel_a;
    logic [BIT_WIDTH-1:0]   w_sel_b;
    logic [2*BIT_WIDTH-1:0] w_prod;
    logic                   w_rsp_hs;

    assign w_s2_adv  = !r_v2 || rsp_ready;
    assign w_s1_adv  = !r_v1 || w_s2_adv;
    assign w_arb_en  = w_s1_adv && rst_n;
    assign w_xfer    = w_arb_en && w_gnt_vld;
    assign w_rsp_hs  = r_v2 && rsp_ready;
    assign w_sel_a   = req_a[w_gnt_idx*BIT_WIDTH +: BIT_WIDTH];
    assign w_sel_b   = req_b[w_gnt_idx*BIT_WIDTH +: BIT_WIDTH];

    mbm_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    MBM_multiplier u_mult (
        .operand_a (r_s1_a),
        .operand_b (r_s1_b),
        .product   (w_prod)
    );

    // S1: capture the granted request whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_id <= '0;
        end else if (w_s1_adv) begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_s1_a  <= w_sel_a;
                r_s1_b  <= w_sel_b;
                r_s1_id <= w_gnt_idx;
            end
        end
    end

    // S2: register the product; contents hold while the response is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v2      <= 1'b0;
            r_s2_prod <= '0;
            r_s2_id   <= '0;
        end else if (w_s2_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_prod <= w_prod;
                r_s2_id   <= r_s1_id;
            end
        end
    end

    // Round-robin pointer moves past the requester that just transferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= ID_W'(rr_next(32'(w_gnt_idx), NUM_REQ));
        end
    end

    // Accepted-result counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_rsp_hs) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    // Requesters must never present unknown valids once out of reset.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!$isunknown(req_valid));
    end

    assign req_ready   = w_gnt;
    assign rsp_valid   = r_v2;
    assign rsp_product = r_s2_prod;
    assign rsp_id      = r_s2_id;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_mbm_mult_scheduler.sv
// Self-checking bench for mbm_mult_scheduler: directed table, multi-cycle
// corner sequences, random traffic against a per-requester scoreboard.
module tb_mbm_mult_scheduler;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_a;
    logic [NR*8-1:0] req_b;
    logic [NR-1:0] req_ready;
    logic          rsp_valid;
    logic [15:0]   rsp_product;
    logic [1:0]    rsp_id;
    logic          rsp_ready;
    logic [31:0]   op_count;

    int checks   = 0;
    int failures = 0;
    int n_ops    = 0;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[8];

    logic [7:0]  pa[NR];
    logic [7:0]  pb[NR];
    logic [15:0] q[NR][$];

    mbm_mult_scheduler #(
        .NUM_REQ   (NR),
        .BIT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .rsp_ready   (rsp_ready),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Q7 fixed-point log-domain reference of the approximate product.
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
        int ka, kb, fa, fb, sum;
        longint p;
        if (a == 0 || b == 0) return 16'd0;
        ka = 0; kb = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) ka = i;
            if (b[i]) kb = i;
        end
        fa  = (int'(a) << (7 - ka)) - 128;
        fb  = (int'(b) << (7 - kb)) - 128;
        sum = fa + fb;
        if (sum < 128) p = (longint'(128 + sum) << (ka + kb)) >>> 7;
        else           p = (longint'(sum) << (ka + kb + 1)) >>> 7;
        return 16'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_slot(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
    endtask

    // One request cycle with a valid mask and the grant it must produce.
    task automatic one_grant(input string nm, input logic [NR-1:0] mask, input logic [NR-1:0] exp);
        req_valid = mask;
        #1;
        chk(nm, 32'(req_ready), 32'(exp));
        tick();
        req_valid = '0;
    endtask

    initial begin
        int          xfers;
        int          issued, retired, cyc, npend;
        bit          pend[NR];
        logic [7:0]  ra[NR];
        logic [7:0]  rb[NR];
        bit          prev_stall;
        logic [15:0] prev_p;
        logic [1:0]  prev_id;
        logic [15:0] e;

        vecs[0] = '{0,   8'd3,   8'd5, 16'd14};
        vecs[1] = '{1,   8'd7,   8'd7, 16'd48};
        vecs[2] = '{2, 8'd200,   8'd3, 16'd544};
        vecs[3] = '{3, 8'd255, 8'd255, 16'd65024};
        vecs[4] = '{1,   8'd0,  8'd77, 16'd0};
        vecs[5] = '{2,  8'd16,  8'd10, 16'd160};
        vecs[6] = '{0,  8'd12,  8'd12, 16'd128};
        vecs[7] = '{3,   8'd1,   8'd1, 16'd1};
        for (int i = 0; i < NR; i++) begin
            pa[i] = 8'(10 + 7 * i);
            pb[i] = 8'(20 + 3 * i);
        end

        // Reset held with every requester asking.
        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_op_count", op_count, 0);
        end
        chk("rst_product", 32'(rsp_product), 0);
        chk("rst_id", 32'(rsp_id), 0);
        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        tick();

        // Table: isolated single ops, latency and product per requester.
        foreach (vecs[v]) begin
            set_slot(vecs[v].id, vecs[v].a, vecs[v].b);
            req_valid = '0;
            req_valid[vecs[v].id] = 1'b1;
            #1;
            chk("tbl_grant", 32'(req_ready), 32'(1) << vecs[v].id);
            tick();
            req_valid = '0;
            chk("tbl_lat_early", 32'(rsp_valid), 0);
            tick();
            chk("tbl_rsp_valid", 32'(rsp_valid), 1);
            chk("tbl_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
            chk("tbl_product", 32'(rsp_product), 32'(vecs[v].exp));
            tick();
            n_ops++;
            chk("tbl_op_count", op_count, 32'(n_ops));
        end

        // Round robin with all requesters valid, pointer starts at 0.
        for (int i = 0; i < NR; i++) set_slot(i, pa[i], pb[i]);
        req_valid = '1;
        for (int k = 0; k < 14; k++) begin
            if (k >= 12) req_valid = '0;
            #1;
            if (k < 12) chk("rr_grant", 32'(req_ready), 32'(1) << (k % NR));
            if (k >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % NR));
                chk("rr_product", 32'(rsp_product), 32'(golden(pa[(k-2)%NR], pb[(k-2)%NR])));
            end
            tick();
        end
        n_ops += 12;
        chk("rr_drained", 32'(rsp_valid), 0);
        chk("rr_op_count", op_count, 32'(n_ops));

        // Backpressure: pipe fills with two ops then refuses further grants.
        req_valid = '1; rsp_ready = 1'b0; xfers = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if ((req_valid & req_ready) != 0) xfers++;
            if (k == 0) chk("bp_grant0", 32'(req_ready), 32'h1);
            if (k == 1) chk("bp_grant1", 32'(req_ready), 32'h2);
            if (k >= 2) begin
                chk("bp_full_ready", 32'(req_ready), 0);
                chk("bp_hold_id", 32'(rsp_id), 0);
                chk("bp_hold_prod", 32'(rsp_product), 32'(golden(pa[0], pb[0])));
            end
            tick();
        end
        chk("bp_xfers", 32'(xfers), 2);
        req_valid = '0; rsp_ready = 1'b1;
        #1;
        chk("bp_rel_id0", {31'b0, rsp_valid} << 8 | 32'(rsp_id), 32'h100);
        tick();
        chk("bp_rel_id1", {31'b0, rsp_valid} << 8 | 32'(rsp_id), 32'h101);
        chk("bp_rel_prod1", 32'(rsp_product), 32'(golden(pa[1], pb[1])));
        tick();
        chk("bp_rel_empty", 32'(rsp_valid), 0);
        n_ops += 2;
        chk("bp_op_count", op_count, 32'(n_ops));

        // Pointer wrap: pointer now at 2.
        one_grant("wr_g2", 4'b0100, 4'b0100);
        one_grant("wr_wrap_g0", 4'b0101, 4'b0001);
        one_grant("wr_g3", 4'b1000, 4'b1000);
        one_grant("wr_after3_g0", 4'b0101, 4'b0001);
        one_grant("wr_g2_from1", 4'b0101, 4'b0100);
        tick(); tick(); tick();
        n_ops += 5;
        chk("wr_op_count", op_count, 32'(n_ops));

        // Reset while both stages hold ops (pointer at 3, then 0, ends at 1).
        req_valid = '1; rsp_ready = 1'b0;
        tick(); tick();
        chk("mr_full", {31'b0, rsp_valid} << 4 | 32'(req_ready), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("mr_ready_in_rst", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        chk("mr_rsp_valid", 32'(rsp_valid), 0);
        chk("mr_op_count", op_count, 0);
        #1;
        chk("mr_ptr_zero", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("mr_no_replay", 32'(rsp_valid), 0);
        tick();
        chk("mr_rsp_id", {31'b0, rsp_valid} << 4 | 32'(rsp_id), 32'h10);
        chk("mr_rsp_prod", 32'(rsp_product), 32'(golden(pa[0], pb[0])));
        tick();
        chk("mr_empty", 32'(rsp_valid), 0);
        n_ops = 1;
        chk("mr_op_count1", op_count, 32'(n_ops));

        // Random traffic against per-requester in-order scoreboard.
        issued = 0; retired = 0; cyc = 0; prev_stall = 0; prev_p = '0; prev_id = '0;
        for (int i = 0; i < NR; i++) pend[i] = 0;
        while ((issued < 10000 || retired < issued) && cyc < 80000) begin
            npend = 0;
            for (int i = 0; i < NR; i++) npend += int'(pend[i]);
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && issued + npend < 10000 && $urandom_range(2) == 0) begin
                    pend[i] = 1; npend++;
                    ra[i] = 8'($urandom); rb[i] = 8'($urandom);
                    if ($urandom_range(15) == 0) ra[i] = 8'd255;
                    if ($urandom_range(15) == 0) rb[i] = 8'd0;
                    set_slot(i, ra[i], rb[i]);
                end
                req_valid[i] = pend[i];
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            chk("rand_grant_legal",
                32'(($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == 0)), 1);
            if (prev_stall) begin
                chk("rand_stall_hold", {15'b0, rsp_valid, rsp_product} | (32'(rsp_id) << 20),
                    {15'b0, 1'b1, prev_p} | (32'(prev_id) << 20));
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q[i].push_back(golden(ra[i], rb[i]));
                    pend[i] = 0;
                    issued++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (q[rsp_id].size() == 0) begin
                    chk("rand_unexpected_rsp", 32'(rsp_id), 32'hFFFF);
                end else begin
                    e = q[rsp_id].pop_front();
                    chk("rand_product", 32'(rsp_product), 32'(e));
                end
                retired++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_p = rsp_product; prev_id = rsp_id;
            tick();
            cyc++;
        end
        req_valid = '0; rsp_ready = 1'b1;
        chk("rand_retired", 32'(retired), 10000);
        n_ops += 10000;
        chk("rand_op_count", op_count, 32'(n_ops));

        // Counter wrap from all-ones.
        force dut.r_op_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_op_count;
        #1;
        chk("wrap_preset", op_count, 32'hFFFF_FFFF);
        set_slot(2, 8'd3, 8'd5);
        one_grant("wrap_grant", 4'b0100, 4'b0100);
        tick();
        chk("wrap_rsp", {31'b0, rsp_valid} << 4 | 32'(rsp_id), 32'h12);
        tick();
        chk("wrap_zero", op_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
